fir_sym_pipe: RTL and testbench



---
 rtl/fir_sym_pkg.sv | 35 +++
 rtl/fir_sym_pipe_if.sv | 33 +++
 rtl/fir_sym_addtree.sv | 51 +++++
 rtl/fir_sym_pipe.sv | 100 ++++++++++
 tb/tb_fir_sym_pipe.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_sym_pkg.sv
// Shared constants and helpers for the symmetric FIR pipeline.
// Provides the default coefficient set, clog2 and the internal sum width.
package fir_sym_pkg;

    localparam int N_DEF_COEF = 5;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v)
                r = i + 1;
        return r;
    endfunction

    function automatic int def_coef(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            2:       return 6;
            3:       return 10;
            4:       return 12;
            default: return 0;
        endcase
    endfunction

    function automatic int sum_width(
        input int dw,
        input int cw,
        input int nhalf
    );
        return dw + 1 + cw + clog2(nhalf);
    endfunction

endpackage

// File: rtl/fir_sym_pipe_if.sv
// Sample-in / result-out valid-ready stream bundle for fir_sym_pipe.
// master drives samples and accepts results; slave is the filter.
interface fir_sym_pipe_if #(
    parameter int DATA_W = 4,
    parameter int OUT_W  = 12
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/fir_sym_addtree.sv
// Single-stage registered reduction of the tap products.
// Output reduction wraps by default; define FIR_SYM_SAT_EN to saturate.
module fir_sym_addtree #(
    parameter int N     = 5,
    parameter int IN_W  = 9,
    parameter int SUM_W = 12,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  prod [N],
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data
);

    logic [SUM_W-1:0] sum;
    logic [OUT_W-1:0] res;

    always_comb begin
        sum = '0;
        for (int k = 0; k < N; k++)
            sum = sum + SUM_W'(prod[k]);
    end

    generate
        if (OUT_W < SUM_W) begin : g_reduce
`ifdef FIR_SYM_SAT_EN
            assign res = (|sum[SUM_W-1:OUT_W]) ? '1 : sum[OUT_W-1:0];
`else
            assign res = OUT_W'(sum);
`endif
        end else begin : g_extend
            assign res = OUT_W'(sum);
        end
    endgenerate

    // out_data only moves with a real result so it holds across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= res;
        end
    end

endmodule

// File: rtl/fir_sym_pipe.sv
// Pipelined symmetric FIR: delay line, pre-add, multiply, sum.
// Optional FIR_SYM_SAT_EN saturates the result instead of wrapping.
module fir_sym_pipe
    import fir_sym_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int COEF_W = 4,
    parameter int NTAPS  = 9,
    parameter int OUT_W  = 12,
    localparam int NHALF = (NTAPS + 1) / 2,
    localparam int AW    = clog2(NHALF),
    localparam int SUM_W = sum_width(DATA_W, COEF_W, NHALF)
) (
    input  logic              clk,
    input  logic              rst,
    fir_sym_pipe_if.slave     s,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_wdata
);

    localparam int PW = DATA_W + 1;
    localparam int MW = PW + COEF_W;

    logic              stall;
    logic              accept;
    logic              v0, v1, v2;
    logic [DATA_W-1:0] x [NTAPS];
    logic [PW-1:0]     p [NHALF];
    logic [COEF_W-1:0] c [NHALF];
    logic [MW-1:0]     m [NHALF];

    assign stall    = s.out_valid & ~s.out_ready;
    assign s.in_ready = ~stall;
    assign accept   = s.in_valid & ~stall;

    // v0 marks that x holds a freshly shifted window to pre-add
    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            for (int k = 0; k < NTAPS; k++)
                x[k] <= '0;
        end else if (!stall) begin
            v0 <= accept;
            if (accept) begin
                x[0] <= s.in_data;
                for (int k = 1; k < NTAPS; k++)
                    x[k] <= x[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (!stall) begin
            v1 <= v0;
            for (int k = 0; k < NHALF - 1; k++)
                p[k] <= {1'b0, x[k]} + {1'b0, x[NTAPS-1-k]};
            p[NHALF-1] <= {1'b0, x[NHALF-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NHALF; k++)
                c[k] <= COEF_W'(def_coef(k));
        end else begin
            for (int k = 0; k < NHALF; k++)
                if (coef_we && (int'(coef_addr) == k))
                    c[k] <= coef_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (!stall) begin
            v2 <= v1;
            for (int k = 0; k < NHALF; k++)
                m[k] <= MW'(p[k]) * MW'(c[k]);
        end
    end

    fir_sym_addtree #(
        .N     (NHALF),
        .IN_W  (MW),
        .SUM_W (SUM_W),
        .OUT_W (OUT_W)
    ) u_addtree (
        .clk       (clk),
        .rst       (rst),
        .en        (~stall),
        .in_valid  (v2),
        .prod      (m),
        .out_valid (s.out_valid),
        .out_data  (s.out_data)
    );

endmodule

// File: tb/tb_fir_sym_pipe.sv
// Scoreboard bench for fir_sym_pipe with directed vectors.
// A second 9-bit-output instance covers the wrap/saturate reduction.
module tb_fir_sym_pipe;

    logic       clk;
    logic       rst;
    logic       coef_we;
    logic [2:0] coef_addr;
    logic [3:0] coef_wdata;

    fir_sym_pipe_if #(.DATA_W(4), .OUT_W(12)) bus ();
    fir_sym_pipe_if #(.DATA_W(4), .OUT_W(9))  bus9 ();

    fir_sym_pipe #(.DATA_W(4), .COEF_W(4), .NTAPS(9), .OUT_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (bus),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata)
    );

    fir_sym_pipe #(.DATA_W(4), .COEF_W(4), .NTAPS(9), .OUT_W(9)) dut9 (
        .clk        (clk),
        .rst        (rst),
        .s          (bus9),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata)
    );

    assign bus9.in_valid  = bus.in_valid;
    assign bus9.in_data   = bus.in_data;
    assign bus9.out_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_out  = 0;
    int q[$];
    int hist [9];
    int tc [5];

    int imp_def [9] = '{2, 3, 6, 10, 12, 10, 6, 3, 2};
    int imp_mod [9] = '{0, 3, 6, 10, 1, 10, 6, 3, 0};
    int cst_exp [12] = '{30, 75, 165, 315, 495, 645, 735, 780,
                         810, 810, 810, 810};

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int golden();
        int s;
        s = 0;
        for (int k = 0; k < 9; k++)
            s += tc[(k <= 4) ? k : 8 - k] * hist[k];
        return s;
    endfunction

    task automatic hist_push(input int d);
        for (int k = 8; k > 0; k--)
            hist[k] = hist[k-1];
        hist[0] = d;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_out", int'(bus.out_data), -1);
            end else begin
                chk("out_data", int'(bus.out_data), q.pop_front());
                n_out++;
            end
        end
    end

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        coef_we       = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        q.delete();
        for (int k = 0; k < 9; k++)
            hist[k] = 0;
        tc = '{2, 3, 6, 10, 12};
        rst = 1'b0;
    endtask

    task automatic send(input logic [3:0] d, input int e, input bit push);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready)
                ok = 1'b1;
        end
        if (!ok) begin
            chk("send_timeout", 0, 1);
            bus.in_valid = 1'b0;
        end else begin
            hist_push(int'(d));
            if (push)
                q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic coef_write(input logic [2:0] a, input logic [3:0] d);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = d;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        if (a < 3'd5)
            tc[a] = int'(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0;
        int held;
        int idx;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        coef_we       = 1'b0;
        coef_addr     = '0;
        coef_wdata    = '0;
        idle(2);
        do_reset();

        // impulse with latency probe
        send(4'd1, imp_def[0], 1'b1);
        chk("lat_e0", int'(bus.out_valid), 0);
        idle(1);
        chk("lat_e1", int'(bus.out_valid), 0);
        idle(1);
        chk("lat_e2", int'(bus.out_valid), 0);
        idle(1);
        chk("lat_e3_valid", int'(bus.out_valid), 1);
        chk("lat_e3_data", int'(bus.out_data), 2);
        for (int i = 1; i < 9; i++)
            send(4'd0, imp_def[i], 1'b1);
        idle(6);
        chk("impulse_drain", q.size(), 0);

        // constant 15 at full rate
        do_reset();
        n0 = n_out;
        for (int i = 0; i < 12; i++)
            send(4'd15, cst_exp[i], 1'b1);
        idle(3);
        @(negedge clk);
        #1;
        chk("no_bubbles", n_out - n0, 12);
`ifdef FIR_SYM_SAT_EN
        chk("out9_sat", int'(bus9.out_data), 511);
`else
        chk("out9_wrap", int'(bus9.out_data), 298);
`endif
        idle(3);

        // backpressure against the golden model
        do_reset();
        idx  = 1;
        held = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus.in_valid  = (idx <= 20);
            bus.in_data   = 4'(idx);
            bus.out_ready = !(cyc >= 10 && cyc < 15);
            @(negedge clk);
            if (cyc == 10)
                held = int'(bus.out_data);
            if (!bus.out_ready) begin
                chk("stall_in_ready", int'(bus.in_ready), 0);
                chk("stall_out_valid", int'(bus.out_valid), 1);
                chk("stall_hold", int'(bus.out_data), held);
            end
            if (bus.in_valid && bus.in_ready) begin
                hist_push(idx % 16);
                q.push_back(golden());
                idx++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(8);
        chk("bp_all_sent", idx, 21);
        chk("bp_drain", q.size(), 0);

        // runtime coefficients, including an out-of-range write
        do_reset();
        coef_write(3'd4, 4'd1);
        coef_write(3'd0, 4'd0);
        coef_write(3'd6, 4'd15);
        for (int i = 0; i < 9; i++)
            send((i == 0) ? 4'd1 : 4'd0, imp_mod[i], 1'b1);
        idle(6);
        chk("coef_drain", q.size(), 0);

        // reset with three results in flight
        for (int i = 0; i < 3; i++)
            send(4'd5, 0, 1'b0);
        do_reset();
        idle(1);
        chk("rst_flush_valid", int'(bus.out_valid), 0);
        for (int i = 0; i < 9; i++)
            send((i == 0) ? 4'd1 : 4'd0, imp_def[i], 1'b1);
        idle(6);
        chk("final_drain", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
